// File: rtl/flappy_pkg.sv
// Shared Flappy Bird definitions: game-state encoding and default play-field
// geometry used by the bird, pipe and collision blocks.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int X_POS = 180;
    localparam int Y_MIN = 20;
    localparam int Y_MAX = 700;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider that emits a one-cycle physics tick every TICK_DIV clocks.
// Shared by the bird motion engine and the pipe scroller.
module tick_gen #(
    parameter int TICK_DIV = 1485000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bird_motion.sv
// Tick-driven vertical physics for the player sprite: gravity, flap impulse,
// terminal velocity and clamped ceiling/floor, wrapped in an IDLE/FLY/DEAD FSM.
module bird_motion #(
    parameter int PW       = 12,
    parameter int VW       = 8,
    parameter int TICK_DIV = 1485000,
    parameter int X_POS    = flappy_pkg::X_POS,
    parameter int Y_START  = 350,
    parameter int Y_MIN    = flappy_pkg::Y_MIN,
    parameter int Y_MAX    = flappy_pkg::Y_MAX,
    parameter int GRAV     = 1,
    parameter int FLAP_V   = 8,
    parameter int VMAX     = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key1,
    input  logic          key2,
    output logic [PW-1:0] bpos_x,
    output logic [PW-1:0] bpos_y,
    output logic [VW-1:0] vel,
    output logic [1:0]    state,
    output logic          hit_ceiling,
    output logic          hit_ground
);

    import flappy_pkg::*;

    localparam logic signed [VW-1:0] FLAP_NEG = VW'(-FLAP_V);
    localparam logic signed [VW:0]   VMAX_S   = (VW+1)'(VMAX);
    localparam logic signed [VW:0]   GRAV_S   = (VW+1)'(GRAV);
    localparam logic signed [PW+1:0] Y_MIN_S  = (PW+2)'(Y_MIN);
    localparam logic signed [PW+1:0] Y_MAX_S  = (PW+2)'(Y_MAX);
    localparam logic [PW-1:0]        Y_START_U = PW'(Y_START);
    localparam logic [PW-1:0]        Y_MIN_U   = PW'(Y_MIN);
    localparam logic [PW-1:0]        Y_MAX_U   = PW'(Y_MAX);

    logic tick;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    state_t               state_q, state_d;
    logic [PW-1:0]        y_q, y_d;
    logic signed [VW-1:0] vel_q, vel_d;
    logic                 key2_q;
    logic                 pend_q, pend_d;
    logic                 hit_ceil_q, hit_ceil_d;
    logic                 hit_gnd_q, hit_gnd_d;

    logic                 flap_req;
    logic                 flap_now;
    logic signed [VW:0]   v_inc;
    logic signed [VW-1:0] v_new;
    logic signed [PW+1:0] y_new;

    always_comb begin
        flap_req = key2 & ~key2_q;
        // An edge on the tick cycle itself is honoured by that tick.
        flap_now = pend_q | flap_req;

        v_inc = {vel_q[VW-1], vel_q} + GRAV_S;
        if (flap_now) begin
            v_new = FLAP_NEG;
        end else if (v_inc > VMAX_S) begin
            v_new = VMAX_S[VW-1:0];
        end else begin
            v_new = v_inc[VW-1:0];
        end
        // Two guard bits keep the sum from wrapping at either bound.
        y_new = $signed({2'b00, y_q}) + {{(PW+2-VW){v_new[VW-1]}}, v_new};

        state_d    = state_q;
        y_d        = y_q;
        vel_d      = vel_q;
        pend_d     = pend_q | flap_req;
        hit_ceil_d = 1'b0;
        hit_gnd_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_FLY: begin
                if (tick) begin
                    pend_d = 1'b0;
                    if (state_q == ST_FLY || flap_now) begin
                        state_d = ST_FLY;
                        if (y_new <= Y_MIN_S) begin
                            y_d        = Y_MIN_U;
                            vel_d      = '0;
                            hit_ceil_d = 1'b1;
                        end else if (y_new >= Y_MAX_S) begin
                            y_d       = Y_MAX_U;
                            vel_d     = '0;
                            hit_gnd_d = 1'b1;
                            state_d   = ST_DEAD;
                        end else begin
                            y_d   = y_new[PW-1:0];
                            vel_d = v_new;
                        end
                    end
                end
            end
            ST_DEAD: begin
                pend_d = 1'b0;
                if (key1) begin
                    y_d     = Y_START_U;
                    vel_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            y_q        <= Y_START_U;
            vel_q      <= '0;
            key2_q     <= 1'b0;
            pend_q     <= 1'b0;
            hit_ceil_q <= 1'b0;
            hit_gnd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            vel_q      <= vel_d;
            key2_q     <= key2;
            pend_q     <= pend_d;
            hit_ceil_q <= hit_ceil_d;
            hit_gnd_q  <= hit_gnd_d;
        end
    end

    assign bpos_x      = PW'(X_POS);
    assign bpos_y      = y_q;
    assign vel         = vel_q;
    assign state       = state_q;
    assign hit_ceiling = hit_ceil_q;
    assign hit_ground  = hit_gnd_q;

endmodule
